// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller in front of a 128-bit block memory.
// Define DCACHE_STATS_EN to add hit/miss/write-back counters (stat_* outputs).
module dcache_controller #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_address,
  input  logic [31:0]   cpu_writedata,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_busywait,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_address,
  output logic [127:0]  mem_writedata,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_misses,
  output logic [31:0]   stat_writebacks
`endif
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_e;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [TAG_W-1:0]     tag_d  [LINES];
  logic [127:0]         data_q [LINES];
  logic [127:0]         data_d [LINES];
  logic [127:0]         fill_q, fill_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [27:0]          mem_address_q, mem_address_d;
  logic [127:0]         mem_writedata_q, mem_writedata_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            word;
  logic                  request;
  logic                  hit;
  logic                  unused_byte_offset;

  assign idx                = cpu_address[INDEX_BITS+3:4];
  assign tag                = cpu_address[31:INDEX_BITS+4];
  assign word               = cpu_address[3:2];
  assign request            = cpu_read | cpu_write;
  assign hit                = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_byte_offset = ^cpu_address[1:0];

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  // Next-state, line update and CPU handshake; stalls are only released from IDLE.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    tag_d           = tag_q;
    data_d          = data_q;
    fill_d          = fill_q;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    cpu_busywait    = 1'b0;
    cpu_readdata    = 32'd0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (hit) begin
            if (cpu_write) begin
              for (int i = 0; i < 4; i++) begin
                if (word == 2'(i)) data_d[idx][32*i +: 32] = cpu_writedata;
              end
              dirty_d[idx] = 1'b1;
            end else begin
              cpu_readdata = data_q[idx][{word, 5'd0} +: 32];
            end
          end else begin
            cpu_busywait = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d         = WRITEBACK;
              mem_write_d     = 1'b1;
              mem_address_d   = {tag_q[idx], idx};
              mem_writedata_d = data_q[idx];
            end else begin
              state_d       = FETCH;
              mem_read_d    = 1'b1;
              mem_address_d = cpu_address[31:4];
            end
          end
        end
      end
      WRITEBACK: begin
        cpu_busywait = 1'b1;
        if (!mem_busywait) begin
          state_d       = FETCH;
          mem_read_d    = 1'b1;
          mem_address_d = cpu_address[31:4];
        end else begin
          mem_write_d = 1'b1;
        end
      end
      FETCH: begin
        cpu_busywait = 1'b1;
        if (!mem_busywait) begin
          state_d = UPDATE;
          fill_d  = mem_readdata;
        end else begin
          mem_read_d = 1'b1;
        end
      end
      UPDATE: begin
        cpu_busywait = 1'b1;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        tag_d[idx]   = tag;
        data_d[idx]  = fill_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and memory-side request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      fill_q          <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      fill_q          <= fill_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Tag and data arrays are not reset; valid bits guard them.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q, retry_d;
  logic        hit_ev, miss_ev, wb_ev;
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

  // The hit that follows UPDATE is the retried access, already counted as a miss.
  always_comb begin
    retry_d  = (state_q == UPDATE);
    hit_ev   = (state_q == IDLE) && request && hit && !retry_q;
    miss_ev  = (state_q == IDLE) && request && !hit;
    wb_ev    = miss_ev && valid_q[idx] && dirty_q[idx];
    hits_d   = hits_q + 32'(hit_ev);
    misses_d = misses_q + 32'(miss_ev);
    wbs_d    = wbs_q + 32'(wb_ev);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_q  <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      retry_q  <= retry_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model.
module tb_dcache_controller;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write;
  logic [31:0]   cpu_address, cpu_writedata;
  logic [31:0]   cpu_readdata;
  logic          cpu_busywait;
  logic          mem_read, mem_write;
  logic [27:0]   mem_address;
  logic [127:0]  mem_writedata;
  logic [127:0]  mem_readdata;
  logic          mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_writebacks;
`endif

  int checks = 0;
  int errors = 0;

  dcache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: busy for two cycles after a request appears, ready on the third.
  int           mem_cnt = 0;
  int           wr_cycles = 0;
  int           both_cycles = 0;
  logic [27:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;

  function automatic logic [127:0] blk(input logic [27:0] a);
    if (a == 28'h1) return 128'h0123456789ABCDEF0123456789ABCDEF;
    return {16'(a), 16'h0003, 16'(a), 16'h0002, 16'(a), 16'h0001, 16'(a), 16'h0000};
  endfunction

  assign mem_readdata = blk(mem_address);
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < 2);

  always @(posedge clock) begin
    if (mem_write) wr_cycles <= wr_cycles + 1;
    if (mem_read && mem_write) both_cycles <= both_cycles + 1;
    if (reset || !(mem_read || mem_write)) begin
      mem_cnt <= 0;
    end else if (!mem_busywait) begin
      mem_cnt <= 0;
      if (mem_write) begin
        wb_addr <= mem_address;
        wb_data <= mem_writedata;
      end
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock); #1;
      if (!cpu_busywait) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic wait_mem_read(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock); #1;
      if (mem_read) begin
        n = i;
        return;
      end
    end
  endtask

  int n;
  int wr_snap;

  initial begin
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_writedata = '0;
    @(negedge clock); @(negedge clock); #1;
    chk("rst_busywait", 128'(cpu_busywait), 128'd0);
    chk("rst_mem_read", 128'(mem_read), 128'd0);
    chk("rst_mem_write", 128'(mem_write), 128'd0);
    chk("rst_mem_address", 128'(mem_address), 128'd0);
    chk("rst_mem_writedata", mem_writedata, 128'd0);
    chk("rst_readdata", 128'(cpu_readdata), 128'd0);
    reset = 1'b0;

    // 1: cold read miss on 0x10
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 32'h10; #1;
    chk("t1_busy_same_cycle", 128'(cpu_busywait), 128'd1);
    @(negedge clock); #1;
    chk("t1_mem_read", 128'(mem_read), 128'd1);
    chk("t1_mem_write", 128'(mem_write), 128'd0);
    chk("t1_mem_address", 128'(mem_address), 128'h1);
    wait_idle(n);
    chk("t1_latency", 128'(n), 128'd4);
    chk("t1_readdata", 128'(cpu_readdata), 128'h89ABCDEF);
    chk("t1_no_writeback", 128'(wr_cycles), 128'd0);

    // 2: write hit to 0x14 then read it back
    @(negedge clock);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 32'h14; cpu_writedata = 32'hDEADBEEF; #1;
    chk("t2_write_busy", 128'(cpu_busywait), 128'd0);
    @(negedge clock); #1;
    chk("t2_mem_idle", 128'({mem_read, mem_write}), 128'd0);
    cpu_write = 1'b0; cpu_read = 1'b1; #1;
    chk("t2_read_busy", 128'(cpu_busywait), 128'd0);
    chk("t2_readdata", 128'(cpu_readdata), 128'hDEADBEEF);

    // 3: dirty conflict miss on 0x94 (index 1, tag 1)
    @(negedge clock);
    cpu_address = 32'h94; #1;
    chk("t3_busy", 128'(cpu_busywait), 128'd1);
    @(negedge clock); #1;
    chk("t3_mem_write", 128'(mem_write), 128'd1);
    chk("t3_mem_read_off", 128'(mem_read), 128'd0);
    chk("t3_wb_address", 128'(mem_address), 128'h1);
    chk("t3_wb_word1", 128'(mem_writedata[63:32]), 128'hDEADBEEF);
    chk("t3_wb_block", mem_writedata, 128'h0123456789ABCDEFDEADBEEF89ABCDEF);
    wait_mem_read(n);
    chk("t3_wait_fetch", 128'(n), 128'd3);
    chk("t3_fetch_address", 128'(mem_address), 128'h9);
    chk("t3_fetch_no_write", 128'(mem_write), 128'd0);
    chk("t3_mem_captured", wb_data, 128'h0123456789ABCDEFDEADBEEF89ABCDEF);
    chk("t3_mem_captured_addr", 128'(wb_addr), 128'h1);
    wait_idle(n);
    chk("t3_latency", 128'(n), 128'd4);
    chk("t3_readdata", 128'(cpu_readdata), 128'h00090001);
    @(negedge clock);
    cpu_read = 1'b0; #1;
`ifdef DCACHE_STATS_EN
    chk("stat_hits", 128'(stat_hits), 128'd2);
    chk("stat_misses", 128'(stat_misses), 128'd2);
    chk("stat_writebacks", 128'(stat_writebacks), 128'd1);
`endif

    // 4: clean conflict miss on 0x114 (index 1, tag 2)
    @(negedge clock);
    wr_snap = wr_cycles;
    cpu_read = 1'b1; cpu_address = 32'h114; #1;
    chk("t4_busy", 128'(cpu_busywait), 128'd1);
    @(negedge clock); #1;
    chk("t4_mem_read", 128'({mem_read, mem_write}), 128'b10);
    chk("t4_fetch_address", 128'(mem_address), 128'h11);
    wait_idle(n);
    chk("t4_latency", 128'(n), 128'd4);
    chk("t4_readdata", 128'(cpu_readdata), 128'h00110001);
    chk("t4_no_writeback", 128'(wr_cycles - wr_snap), 128'd0);
    @(negedge clock);
    cpu_read = 1'b0;

    // 5: reset during FETCH aborts the transfer and invalidates the cache
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 32'h20;
    @(negedge clock); #1;
    chk("t5_in_fetch", 128'(mem_read), 128'd1);
    reset = 1'b1; cpu_read = 1'b0;
    @(negedge clock); #1;
    chk("t5_mem_read_drop", 128'(mem_read), 128'd0);
    chk("t5_busy_drop", 128'(cpu_busywait), 128'd0);
    chk("t5_address_clear", 128'(mem_address), 128'd0);
    reset = 1'b0;
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 32'h114; #1;
    chk("t5_prior_misses", 128'(cpu_busywait), 128'd1);
    wait_idle(n);
    chk("t5_refetch_latency", 128'(n), 128'd5);
    chk("t5_readdata", 128'(cpu_readdata), 128'h00110001);
    @(negedge clock);
    cpu_read = 1'b0;

    chk("never_read_and_write", 128'(both_cycles), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
